// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared bank constants, bank-index type and parity helper for the ping-pong buffer.
package pingpong_pkg;
    localparam int NUM_BANKS = 2;
    typedef logic bank_t;
    function automatic logic parity(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/pingpong_bank_ram.sv
// pingpong_bank_ram: simple dual-port synchronous RAM, one write port and one registered read port.
module pingpong_bank_ram #(
    parameter int W      = 17,
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;

    // Storage is never reset; only the read register is, so the output starts at zero.
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/pingpong_buffer.sv
// pingpong_buffer: double-buffered sample store with per-bank commit/release ownership handshake.
// Define PINGPONG_PARITY_EN to store even parity per word and add the rd_parity_err output.
module pingpong_buffer
    import pingpong_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int ADDR_W = 6,
    parameter int DROP_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_bank_valid,
    input  logic              rd_release,
    output logic              wr_sel,
    output logic              rd_sel,
`ifdef PINGPONG_PARITY_EN
    output logic              rd_parity_err,
`endif
    output logic [DROP_W-1:0] drop_cnt
);
`ifdef PINGPONG_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [NUM_BANKS-1:0] full, full_nx;
    logic [MEM_W-1:0]     wword, q0, q1, qsel;
    bank_t                rd_src;
    logic                 wr_acc, commit, rd_acc, release_ok, drop;

    assign wr_ready      = !full[wr_sel];
    assign rd_bank_valid = full[rd_sel];
    assign wr_acc        = wr_en && wr_ready;
    assign commit        = wr_commit && wr_ready;
    assign rd_acc        = rd_en && rd_bank_valid;
    assign release_ok    = rd_release && rd_bank_valid;
    assign drop          = (wr_en || wr_commit) && !wr_ready;

`ifdef PINGPONG_PARITY_EN
    assign wword         = {parity(64'(wr_data)), wr_data};
    assign rd_parity_err = ^qsel;
`else
    assign wword         = wr_data;
`endif

    pingpong_bank_ram #(.W(MEM_W), .ADDR_W(ADDR_W)) u_ram0 (
        .CLK(CLK), .RST_N(RST_N),
        .we(wr_acc && wr_sel == 1'b0), .waddr(wr_addr), .wdata(wword),
        .re(rd_acc && rd_sel == 1'b0), .raddr(rd_addr), .rdata(q0)
    );

    pingpong_bank_ram #(.W(MEM_W), .ADDR_W(ADDR_W)) u_ram1 (
        .CLK(CLK), .RST_N(RST_N),
        .we(wr_acc && wr_sel == 1'b1), .waddr(wr_addr), .wdata(wword),
        .re(rd_acc && rd_sel == 1'b1), .raddr(rd_addr), .rdata(q1)
    );

    // Each RAM holds its last read word, so steering by the last-read bank keeps rd_data stable.
    assign qsel    = rd_src ? q1 : q0;
    assign rd_data = qsel[DATA_W-1:0];

    // Commit and release can only coincide on different banks, so both updates apply.
    always_comb begin
        full_nx = full;
        if (commit) full_nx[wr_sel] = 1'b1;
        if (release_ok) full_nx[rd_sel] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            full     <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            rd_src   <= 1'b0;
            rd_valid <= 1'b0;
            drop_cnt <= '0;
        end else begin
            full     <= full_nx;
            wr_sel   <= commit ? !wr_sel : wr_sel;
            rd_sel   <= release_ok ? !rd_sel : rd_sel;
            rd_src   <= rd_acc ? rd_sel : rd_src;
            rd_valid <= rd_acc;
            drop_cnt <= (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
        end
endmodule
